// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
// Bundles the ID-side operands/control, the EX/MEM and MEM/WB forwarding
// sources, and the EX-side outputs of the ID/EX stage.
//   slave  : the stage itself (consumes ID + forwarding, drives EX outputs)
//   master : whatever sits around it (decode, later stages, a testbench)
// Parameters: WIDTH datapath width, RA_W register-address width.
interface id_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
);
  // decode side
  logic             id_valid;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [WIDTH-1:0] id_imm;
  logic [RA_W-1:0]  id_rs_addr;
  logic [RA_W-1:0]  id_rt_addr;
  logic [RA_W-1:0]  id_rd_addr;
  logic [3:0]       id_alu_ctr;
  logic             id_alu_src;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_mem_to_reg;
  logic             flush;
  // forwarding sources
  logic             exmem_reg_write;
  logic [RA_W-1:0]  exmem_rd_addr;
  logic [WIDTH-1:0] exmem_result;
  logic             memwb_reg_write;
  logic [RA_W-1:0]  memwb_rd_addr;
  logic [WIDTH-1:0] memwb_result;
  // execute side
  logic             stall;
  logic [WIDTH-1:0] alu_input1;
  logic [WIDTH-1:0] alu_input2;
  logic [3:0]       alu_ctr;
  logic [WIDTH-1:0] ex_store_data;
  logic [RA_W-1:0]  ex_rd_addr;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_mem_to_reg;
  logic             ex_valid;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_alu_ctr, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, flush,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    output stall, alu_input1, alu_input2, alu_ctr, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid,
           fwd_a, fwd_b
  );

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_alu_ctr, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, flush,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    input  stall, alu_input1, alu_input2, alu_ctr, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid,
           fwd_a, fwd_b
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with operand forwarding and load-use detection,
// feeding the ALU directly.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, forces the bubble state
//   bus   : id_ex_stage_if.slave (ID fields, flush, EX/MEM + MEM/WB
//           forwarding sources in; stall, ALU operands, registered control,
//           forwarding selects out)
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  logic             ex_valid_q;
  logic [WIDTH-1:0] rs_data_q;
  logic [WIDTH-1:0] rt_data_q;
  logic [WIDTH-1:0] imm_q;
  logic [RA_W-1:0]  rs_addr_q;
  logic [RA_W-1:0]  rt_addr_q;
  logic [RA_W-1:0]  rd_addr_q;
  logic [3:0]       alu_ctr_q;
  logic             alu_src_q;
  logic             reg_write_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic             mem_to_reg_q;

  logic             stall;
  logic             bubble;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;

  // rt is compared even for immediate-form instructions: conservative, and
  // it keeps the detector independent of decode details.
  assign stall = ex_valid_q & mem_read_q & (rd_addr_q != '0) & bus.id_valid &
                 ((rd_addr_q == bus.id_rs_addr) | (rd_addr_q == bus.id_rt_addr));

  // flush outranks stall, but both simply squash the incoming instruction.
  assign bubble = bus.flush | stall | ~bus.id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bubble) begin
      ex_valid_q   <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_addr_q    <= '0;
      alu_ctr_q    <= 4'b0000;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      ex_valid_q   <= 1'b1;
      rs_data_q    <= bus.id_rs_data;
      rt_data_q    <= bus.id_rt_data;
      imm_q        <= bus.id_imm;
      rs_addr_q    <= bus.id_rs_addr;
      rt_addr_q    <= bus.id_rt_addr;
      rd_addr_q    <= bus.id_rd_addr;
      alu_ctr_q    <= bus.id_alu_ctr;
      alu_src_q    <= bus.id_alu_src;
      reg_write_q  <= bus.id_reg_write;
      mem_read_q   <= bus.id_mem_read;
      mem_write_q  <= bus.id_mem_write;
      mem_to_reg_q <= bus.id_mem_to_reg;
    end
  end

  // EX/MEM is checked first because it carries the younger write.
  // Register 0 never matches, so bubbles (rd=0) are never a source.
  always_comb begin
    fwd_rs = rs_data_q;
    sel_a  = FWD_REG;
    if (bus.exmem_reg_write && (bus.exmem_rd_addr != '0) &&
        (bus.exmem_rd_addr == rs_addr_q)) begin
      fwd_rs = bus.exmem_result;
      sel_a  = FWD_EXMEM;
    end else if (bus.memwb_reg_write && (bus.memwb_rd_addr != '0) &&
                 (bus.memwb_rd_addr == rs_addr_q)) begin
      fwd_rs = bus.memwb_result;
      sel_a  = FWD_MEMWB;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    sel_b  = FWD_REG;
    if (bus.exmem_reg_write && (bus.exmem_rd_addr != '0) &&
        (bus.exmem_rd_addr == rt_addr_q)) begin
      fwd_rt = bus.exmem_result;
      sel_b  = FWD_EXMEM;
    end else if (bus.memwb_reg_write && (bus.memwb_rd_addr != '0) &&
                 (bus.memwb_rd_addr == rt_addr_q)) begin
      fwd_rt = bus.memwb_result;
      sel_b  = FWD_MEMWB;
    end
  end

  assign bus.stall         = stall;
  assign bus.alu_input1    = fwd_rs;
  assign bus.alu_input2    = alu_src_q ? imm_q : fwd_rt;
  // Stores always need the forwarded rt, even when operand B is the imm.
  assign bus.ex_store_data = fwd_rt;
  assign bus.alu_ctr       = alu_ctr_q;
  assign bus.ex_rd_addr    = rd_addr_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_mem_to_reg = mem_to_reg_q;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.fwd_a         = sel_a;
  assign bus.fwd_b         = sel_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed scenarios followed by randomized traffic for id_ex_stage, checked
// against a transaction-level model of what the EX slot holds.
module tb_id_ex_stage;
  localparam int WIDTH = 32;
  localparam int RA_W  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.WIDTH(WIDTH), .RA_W(RA_W)) bus ();

  id_ex_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // What the EX slot holds: either nothing (all zero) or a copy of an ID
  // instruction.
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  ctr;
    logic        src;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } ex_t;

  ex_t m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A load in EX whose destination is read by the instruction in ID.
  function automatic logic model_stall();
    return m.valid && m.mr && (m.rd != 0) && bus.id_valid &&
           (m.rd == bus.id_rs_addr || m.rd == bus.id_rt_addr);
  endfunction

  // Newest producer of a register: EX/MEM, then MEM/WB, else the file value.
  task automatic source_of(input logic [4:0] r, input logic [31:0] file_val,
                           output logic [31:0] val, output logic [1:0] sel);
    val = file_val;
    sel = 2'd0;
    if (r != 0) begin
      if (bus.exmem_reg_write && bus.exmem_rd_addr == r) begin
        val = bus.exmem_result;
        sel = 2'd2;
      end else if (bus.memwb_reg_write && bus.memwb_rd_addr == r) begin
        val = bus.memwb_result;
        sel = 2'd1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] va, vb;
    logic [1:0]  sa, sb;
    source_of(m.rs, m.rs_data, va, sa);
    source_of(m.rt, m.rt_data, vb, sb);
    chk({tag, ".stall"},  bus.stall,         model_stall());
    chk({tag, ".in1"},    bus.alu_input1,    va);
    chk({tag, ".in2"},    bus.alu_input2,    m.src ? m.imm : vb);
    chk({tag, ".store"},  bus.ex_store_data, vb);
    chk({tag, ".ctr"},    bus.alu_ctr,       m.ctr);
    chk({tag, ".rd"},     bus.ex_rd_addr,    m.rd);
    chk({tag, ".rw"},     bus.ex_reg_write,  m.rw);
    chk({tag, ".mr"},     bus.ex_mem_read,   m.mr);
    chk({tag, ".mw"},     bus.ex_mem_write,  m.mw);
    chk({tag, ".m2r"},    bus.ex_mem_to_reg, m.m2r);
    chk({tag, ".valid"},  bus.ex_valid,      m.valid);
    chk({tag, ".fwd_a"},  bus.fwd_a,         sa);
    chk({tag, ".fwd_b"},  bus.fwd_b,         sb);
  endtask

  // Advance one clock; the model takes the ID instruction unless it is
  // killed, held back by a load-use, or absent.
  task automatic tick();
    ex_t nxt;
    nxt = '0;
    if (rst_n && !bus.flush && !model_stall() && bus.id_valid) begin
      nxt.valid   = 1'b1;
      nxt.rs_data = bus.id_rs_data;
      nxt.rt_data = bus.id_rt_data;
      nxt.imm     = bus.id_imm;
      nxt.rs      = bus.id_rs_addr;
      nxt.rt      = bus.id_rt_addr;
      nxt.rd      = bus.id_rd_addr;
      nxt.ctr     = bus.id_alu_ctr;
      nxt.src     = bus.id_alu_src;
      nxt.rw      = bus.id_reg_write;
      nxt.mr      = bus.id_mem_read;
      nxt.mw      = bus.id_mem_write;
      nxt.m2r     = bus.id_mem_to_reg;
    end
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [3:0] ctr, input logic src,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    bus.id_valid      = v;
    bus.id_rs_data    = rsd;
    bus.id_rt_data    = rtd;
    bus.id_imm        = imm;
    bus.id_rs_addr    = rs;
    bus.id_rt_addr    = rt;
    bus.id_rd_addr    = rd;
    bus.id_alu_ctr    = ctr;
    bus.id_alu_src    = src;
    bus.id_reg_write  = rw;
    bus.id_mem_read   = mr;
    bus.id_mem_write  = mw;
    bus.id_mem_to_reg = m2r;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_reg_write = ew;
    bus.exmem_rd_addr   = erd;
    bus.exmem_result    = eres;
    bus.memwb_reg_write = mw;
    bus.memwb_rd_addr   = mrd;
    bus.memwb_result    = mres;
  endtask

  task automatic rand_inputs();
    logic [3:0] ops [6];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    set_id(($urandom % 8) != 0, $urandom, $urandom, $urandom,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ops[$urandom_range(0, 5)], 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    bus.flush = ($urandom % 10) == 0;
    set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
            1'($urandom), 5'($urandom_range(0, 3)), $urandom);
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    bus.flush = 0;
    #2;
    check_all("reset");
    rst_n = 1'b1;

    // Capture, then asynchronous reset in mid-cycle, then recapture.
    set_id(1, 5, 7, 0, 1, 2, 9, 4'b0010, 0, 1, 0, 0, 0);
    tick();
    #3;
    check_all("cap1");
    rst_n = 1'b0;
    #1;
    m = '0;
    check_all("async_rst");
    chk("async_rst.in1_zero", bus.alu_input1, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check_all("post_rst");
    chk("post_rst.in1", bus.alu_input1, 32'd5);
    chk("post_rst.in2", bus.alu_input2, 32'd7);
    chk("post_rst.ctr", bus.alu_ctr, 32'b0010);
    chk("post_rst.rd",  bus.ex_rd_addr, 32'd9);

    // EX/MEM beats MEM/WB for operand A.
    set_id(1, 32'h33, 32'h44, 0, 3, 4, 10, 4'b0001, 0, 1, 0, 0, 0);
    tick();
    set_fwd(1, 3, 32'h100, 1, 3, 32'h200);
    #1;
    check_all("prio_exmem");
    chk("prio_exmem.in1", bus.alu_input1, 32'h100);
    chk("prio_exmem.fwd_a", bus.fwd_a, 32'd2);
    bus.exmem_reg_write = 0;
    #1;
    check_all("prio_memwb");
    chk("prio_memwb.in1", bus.alu_input1, 32'h200);
    bus.memwb_reg_write = 0;
    #1;
    check_all("prio_reg");
    chk("prio_reg.in1", bus.alu_input1, 32'h33);

    // Register 0 is never forwarded.
    set_id(1, 32'h11, 32'h77, 0, 1, 0, 12, 4'b0110, 0, 1, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    set_fwd(1, 0, 32'hDEAD, 0, 0, 0);
    #1;
    check_all("r0");
    chk("r0.fwd_b", bus.fwd_b, 32'd0);
    chk("r0.in2", bus.alu_input2, 32'h77);

    // Immediate operand B while the store data still forwards.
    set_id(1, 32'h1, 32'h44, 32'hFFFF_FFFC, 1, 4, 13, 4'b0010, 1, 0, 0, 1, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    set_fwd(1, 4, 32'h55, 0, 0, 0);
    #1;
    check_all("imm");
    chk("imm.in2", bus.alu_input2, 32'hFFFF_FFFC);
    chk("imm.store", bus.ex_store_data, 32'h55);
    chk("imm.fwd_b", bus.fwd_b, 32'd2);

    // Load-use: one bubble, then the held instruction forwards from MEM/WB.
    set_id(1, 0, 0, 32'h10, 1, 2, 8, 4'b0010, 1, 1, 1, 0, 1);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 32'hAA, 32'hBB, 0, 8, 9, 11, 4'b0010, 0, 1, 0, 0, 0);
    #1;
    check_all("lu_stall");
    chk("lu_stall.stall", bus.stall, 32'd1);
    tick();
    check_all("lu_bubble");
    chk("lu_bubble.valid", bus.ex_valid, 32'd0);
    chk("lu_bubble.stall", bus.stall, 32'd0);
    set_fwd(0, 0, 0, 1, 8, 32'h1234);
    tick();
    check_all("lu_resume");
    chk("lu_resume.in1", bus.alu_input1, 32'h1234);
    chk("lu_resume.fwd_a", bus.fwd_a, 32'd1);

    // Flush together with a load-use stall.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 0, 0, 0, 1, 2, 5, 4'b0010, 1, 1, 1, 0, 1);
    tick();
    set_id(1, 32'h9, 32'h9, 0, 5, 3, 6, 4'b0000, 0, 1, 0, 1, 0);
    bus.flush = 1;
    #1;
    chk("flush.stall", bus.stall, 32'd1);
    tick();
    bus.flush = 0;
    check_all("flush");
    chk("flush.valid", bus.ex_valid, 32'd0);
    chk("flush.rw", bus.ex_reg_write, 32'd0);
    chk("flush.mw", bus.ex_mem_write, 32'd0);

    // Randomized traffic on a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      #3;
      check_all("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
